// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier with a Start/Busy/Done
// handshake. One WIDTH-bit adder is reused over WIDTH clock cycles. Each
// iteration adds the multiplicand into the upper half of the accumulator when
// the current multiplier LSB is set, then shifts right and keeps the carry.
// Optional build macro: SHIFT_ADD_MULT_ZERO_SKIP_EN. When it is defined, a zero
// operand finishes in one cycle without entering RUN.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic               accept;
  logic               zero_op;

  // One partial-product step: conditional add into the upper half, then shift right with the carry.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_next = {sum, acc[WIDTH-1:1]};
    accept   = Start && ((state == IDLE) || (state == DONE));
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    zero_op  = (A == '0) || (B == '0);
`else
    zero_op  = 1'b0;
`endif
  end

  // Control FSM, datapath registers and the registered result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      Product <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (accept) begin
            if (zero_op) begin
              Product <= '0;
              Done    <= 1'b1;
              Busy    <= 1'b0;
              state   <= DONE;
            end else begin
              mcand <= A;
              acc   <= {{WIDTH{1'b0}}, B};
              count <= '0;
              Busy  <= 1'b1;
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            Product <= acc_next;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of shift_add_multiplier at WIDTH=4
// and WIDTH=8, with expected values worked out by hand.
module tb_shift_add_multiplier;

  logic        clk;
  logic        reset;
  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [7:0]  product4;
  logic        busy4;
  logic        done4;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] product8;
  logic        busy8;
  logic        done8;

  int total = 0;
  int bad   = 0;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(reset), .Start(start4), .A(a4), .B(b4),
    .Product(product4), .Busy(busy4), .Done(done4)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(reset), .Start(start8), .A(a8), .B(b8),
    .Product(product8), .Busy(busy8), .Done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    #12;
    check("rst_product4", 32'(product4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_product8", 32'(product8), 32'd0);
    tick();
    reset = 1'b0;

    // 13 * 11 = 143
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd11;
    tick();
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    for (int i = 1; i <= 3; i++) begin
      check("t1_busy_run", 32'(busy4), 32'd1);
      check("t1_done_run", 32'(done4), 32'd0);
      tick();
    end
    check("t1_busy_run4", 32'(busy4), 32'd1);
    tick();
    check("t1_done", 32'(done4), 32'd1);
    check("t1_busy_done", 32'(busy4), 32'd0);
    check("t1_product", 32'(product4), 32'd143);
    tick();
    check("t1_done_fall", 32'(done4), 32'd0);
    check("t1_hold", 32'(product4), 32'd143);

    // 15 * 15 = 225, carry into the top bit
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t2_done_early", 32'(done4), 32'd0);
    tick();
    check("t2_done", 32'(done4), 32'd1);
    check("t2_product", 32'(product4), 32'd225);
    tick();

    // 0 * 9 = 0
    start4 = 1'b1; a4 = 4'd0; b4 = 4'd9;
    tick();
    start4 = 1'b0;
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    check("t3_done_fast", 32'(done4), 32'd1);
    check("t3_busy_never", 32'(busy4), 32'd0);
    check("t3_product", 32'(product4), 32'd0);
    tick();
    check("t3_done_fall", 32'(done4), 32'd0);
    check("t3_busy_after", 32'(busy4), 32'd0);
`else
    check("t3_busy", 32'(busy4), 32'd1);
    check("t3_product_hold", 32'(product4), 32'd225);
    for (int i = 0; i < 3; i++) tick();
    check("t3_done_early", 32'(done4), 32'd0);
    tick();
    check("t3_done", 32'(done4), 32'd1);
    check("t3_product", 32'(product4), 32'd0);
    tick();
`endif

    // 7 * 6 = 42, with a second Start during RUN that must be ignored
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd6;
    tick();
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    tick();
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    tick();
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    check("t4_busy_mid", 32'(busy4), 32'd1);
    tick();
    tick();
    check("t4_done", 32'(done4), 32'd1);
    check("t4_product", 32'(product4), 32'd42);
    tick();
    tick();
    check("t4_idle_busy", 32'(busy4), 32'd0);
    check("t4_idle_done", 32'(done4), 32'd0);
    check("t4_hold", 32'(product4), 32'd42);

    // 9 * 5 aborted by an asynchronous reset in the middle of RUN
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd5;
    tick();
    start4 = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("t5_rst_product", 32'(product4), 32'd0);
    check("t5_rst_busy", 32'(busy4), 32'd0);
    check("t5_rst_done", 32'(done4), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd3;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_done", 32'(done4), 32'd1);
    check("t5_product", 32'(product4), 32'd6);

    // WIDTH=8: 255 * 255 = 65025, then 16 * 16 = 256 back-to-back
    start8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("t6_done_early", 32'(done8), 32'd0);
    tick();
    check("t6_done1", 32'(done8), 32'd1);
    check("t6_product1", 32'(product8), 32'd65025);
    start8 = 1'b1; a8 = 8'd16; b8 = 8'd16;
    tick();
    start8 = 1'b0;
    check("t6_b2b_busy", 32'(busy8), 32'd1);
    check("t6_b2b_done", 32'(done8), 32'd0);
    check("t6_b2b_hold", 32'(product8), 32'd65025);
    for (int i = 0; i < 8; i++) tick();
    check("t6_done2", 32'(done8), 32'd1);
    check("t6_product2", 32'(product8), 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
